// File: rtl/matmul_engine.sv
// Sequential matrix multiplier: R = A x B, one multiply-accumulate per two cycles,
// operands fetched from external synchronous-read memories, results written row-major.
module matmul_engine #(
    parameter int DW = 8,
    parameter int M  = 10,
    parameter int K  = 10,
    parameter int N  = 10,
    parameter int AW = 16,
    localparam int RW = 2 * DW + $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_mode,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          a_rd_en,
    output logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_rd_data,
    output logic          b_rd_en,
    output logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_rd_data,
    output logic          r_wr_en,
    output logic [AW-1:0] r_addr,
    output logic [RW-1:0] r_wr_data
);

    typedef enum logic [2:0] {IDLE, FETCH, ACC, STORE, DONE} state_t;

    state_t state_reg, state_next;

    logic [AW-1:0] i_reg, j_reg, k_reg;
    // Running linear addresses, stepped incrementally so no multiplier is needed
    logic [AW-1:0] a_idx_reg, b_idx_reg, r_idx_reg;
    logic [AW-1:0] a_hold_reg, b_hold_reg, r_hold_reg;
    logic [RW-1:0] acc_reg;
    logic          job_signed_reg;

    logic                 last_elem;
    logic                 last_k;
    logic [2*DW-1:0]      prod_u;
    logic signed [2*DW-1:0] prod_s;
    logic [RW-1:0]        prod_ext;

    assign last_k    = (k_reg == AW'(K - 1));
    assign last_elem = (i_reg == AW'(M - 1)) && (j_reg == AW'(N - 1));

    assign prod_u = {{DW{1'b0}}, a_rd_data} * {{DW{1'b0}}, b_rd_data};
    assign prod_s = $signed({{DW{a_rd_data[DW-1]}}, a_rd_data}) *
                    $signed({{DW{b_rd_data[DW-1]}}, b_rd_data});
    assign prod_ext = job_signed_reg ? {{(RW - 2 * DW){prod_s[2*DW-1]}}, prod_s}
                                     : {{(RW - 2 * DW){1'b0}}, prod_u};

    // Addresses show the live index only while strobed, otherwise the last one issued
    assign a_addr    = a_rd_en ? a_idx_reg : a_hold_reg;
    assign b_addr    = b_rd_en ? b_idx_reg : b_hold_reg;
    assign r_addr    = r_wr_en ? r_idx_reg : r_hold_reg;
    assign r_wr_data = acc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        r_wr_en    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start && !abort) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    a_rd_en    = 1'b1;
                    b_rd_en    = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (abort)       state_next = IDLE;
                else if (last_k) state_next = STORE;
                else             state_next = FETCH;
            end
            STORE: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    r_wr_en    = 1'b1;
                    state_next = last_elem ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            a_idx_reg      <= '0;
            b_idx_reg      <= '0;
            r_idx_reg      <= '0;
            a_hold_reg     <= '0;
            b_hold_reg     <= '0;
            r_hold_reg     <= '0;
            acc_reg        <= '0;
            job_signed_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        i_reg          <= '0;
                        j_reg          <= '0;
                        k_reg          <= '0;
                        a_idx_reg      <= '0;
                        b_idx_reg      <= '0;
                        r_idx_reg      <= '0;
                        acc_reg        <= '0;
                        job_signed_reg <= signed_mode;
                    end
                end
                FETCH: begin
                    if (!abort) begin
                        a_hold_reg <= a_idx_reg;
                        b_hold_reg <= b_idx_reg;
                    end
                end
                ACC: begin
                    if (!abort) begin
                        acc_reg <= acc_reg + prod_ext;
                        if (!last_k) begin
                            k_reg     <= k_reg + AW'(1);
                            a_idx_reg <= a_idx_reg + AW'(1);
                            b_idx_reg <= b_idx_reg + AW'(N);
                        end
                    end
                end
                STORE: begin
                    if (!abort) begin
                        r_hold_reg <= r_idx_reg;
                        r_idx_reg  <= r_idx_reg + AW'(1);
                        acc_reg    <= '0;
                        k_reg      <= '0;
                        // a_idx sits at i*K+K-1 here: step to the next row or rewind this one
                        if (j_reg == AW'(N - 1)) begin
                            j_reg     <= '0;
                            i_reg     <= i_reg + AW'(1);
                            a_idx_reg <= a_idx_reg + AW'(1);
                            b_idx_reg <= '0;
                        end else begin
                            j_reg     <= j_reg + AW'(1);
                            a_idx_reg <= a_idx_reg - AW'(K - 1);
                            b_idx_reg <= j_reg + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine (2x3 times 3x2): expected writes are queued
// at job launch and a negedge monitor pops and compares each R write.
module tb_matmul_engine;
    localparam int DW = 8;
    localparam int M  = 2;
    localparam int K  = 3;
    localparam int N  = 2;
    localparam int AW = 16;
    localparam int RW = 18;
    localparam int JOB_CYCLES = M * N * (2 * K + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done;
    logic          a_rd_en, b_rd_en, r_wr_en;
    logic [AW-1:0] a_addr, b_addr, r_addr;
    logic [DW-1:0] a_rd_data, b_rd_data;
    logic [RW-1:0] r_wr_data;

    logic [DW-1:0] mem_a [0:7];
    logic [DW-1:0] mem_b [0:7];

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;

    matmul_engine #(.DW(DW), .M(M), .K(K), .N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .abort(abort),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd_data(b_rd_data),
        .r_wr_en(r_wr_en), .r_addr(r_addr), .r_wr_data(r_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_addr[2:0]];
        if (b_rd_en) b_rd_data <= mem_b[b_addr[2:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (r_wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", r_addr, r_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(r_addr), 32'(mon_e.addr));
                check("wr_data", 32'(r_wr_data), 32'(mon_e.data));
                $display("write addr=%0d data=%0d (expected addr=%0d data=%0d)",
                         r_addr, r_wr_data, mon_e.addr, mon_e.data);
            end
        end
    end

    task automatic load(input logic [47:0] apack, input logic [47:0] bpack);
        for (int x = 0; x < 6; x++) begin
            mem_a[x] = apack[8*x +: 8];
            mem_b[x] = bpack[8*x +: 8];
        end
    endtask

    task automatic push(input int addr, input logic [RW-1:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push4(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                         input logic [RW-1:0] r2, input logic [RW-1:0] r3);
        push(0, r0);
        push(1, r1);
        push(2, r2);
        push(3, r3);
    endtask

    // Returns in cycle 1 of the job (start accepted at edge 0)
    task automatic start_job(input logic sm);
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_mode = sm;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_cycle1", 32'(busy), 32'd1);
    endtask

    // Optionally re-pulses start and flips signed_mode mid-job and during DONE
    task automatic wait_done(input logic disturb);
        int cyc;
        int found;
        int done_before;
        cyc = 1;
        found = 0;
        done_before = done_cnt;
        while (cyc <= 200) begin
            if (done) begin
                found = 1;
                break;
            end
            if (disturb && cyc == 5) begin
                start = 1'b1;
                signed_mode = ~signed_mode;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_cycle", found ? 32'(cyc) : 32'hFFFF_FFFF, 32'(JOB_CYCLES));
        check("busy_in_done", 32'(busy), 32'd0);
        if (disturb) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt - done_before), 32'd1);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_job", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_a_rd_en", 32'(a_rd_en), 32'd0);
        check("rst_b_rd_en", 32'(b_rd_en), 32'd0);
        check("rst_r_wr_en", 32'(r_wr_en), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        check("rst_r_addr", 32'(r_addr), 32'd0);
        check("rst_r_wr_data", 32'(r_wr_data), 32'd0);
    endtask

    localparam logic [47:0] A_SEQ = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [47:0] B_SEQ = {8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};

    initial begin
        int done_before;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // A=[[1,2,3],[4,5,6]], B=[[1,0],[0,1],[1,1]] -> R=[[4,5],[10,11]]
        load(A_SEQ, B_SEQ);
        push4(18'd4, 18'd5, 18'd10, 18'd11);
        start_job(1'b0);
        wait_done(1'b0);

        // All 255 unsigned: 3*65025
        load({6{8'hFF}}, {6{8'hFF}});
        push4(18'd195075, 18'd195075, 18'd195075, 18'd195075);
        start_job(1'b0);
        wait_done(1'b0);

        // -128 * 127 signed: 3*-16256 = -48768 -> 2^18-48768
        load({6{8'h80}}, {6{8'h7F}});
        push4(18'd213376, 18'd213376, 18'd213376, 18'd213376);
        start_job(1'b1);
        wait_done(1'b0);

        // Same bytes unsigned: 3*128*127
        push4(18'd48768, 18'd48768, 18'd48768, 18'd48768);
        start_job(1'b0);
        wait_done(1'b0);

        // -128 * -128 signed: 3*16384
        load({6{8'h80}}, {6{8'h80}});
        push4(18'd49152, 18'd49152, 18'd49152, 18'd49152);
        start_job(1'b1);
        wait_done(1'b0);

        // Extra start pulses and signed_mode flips must not disturb an unsigned job
        load({6{8'hFF}}, {6{8'hFF}});
        push4(18'd195075, 18'd195075, 18'd195075, 18'd195075);
        start_job(1'b0);
        wait_done(1'b1);

        // Abort in cycle 9: first ACC of element (0,1); only address 0 is written
        load(A_SEQ, B_SEQ);
        push(0, 18'd4);
        done_before = done_cnt;
        start_job(1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_state_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
        check("abort_writes", 32'(exp_q.size()), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        push4(18'd4, 18'd5, 18'd10, 18'd11);
        start_job(1'b0);
        wait_done(1'b0);

        // Reset during the STORE of element 2 (cycle 21): elements 0 and 1 written only
        push(0, 18'd4);
        push(1, 18'd5);
        done_before = done_cnt;
        start_job(1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("store_elem2", 32'(r_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt - done_before), 32'd0);
        check("rst_writes", 32'(exp_q.size()), 32'd0);

        push4(18'd4, 18'd5, 18'd10, 18'd11);
        start_job(1'b0);
        wait_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter DW, default 8, element width of A and B.
REQ-002 Parameter M, default 10, rows of A and R.
REQ-003 Parameter K, default 10, columns of A and rows of B; K >= 2.
REQ-004 Parameter N, default 10, columns of B and R.
REQ-005 Parameter AW, default 16, address width of all memory ports; 2^AW >= max(M*K, K*N, M*N).
REQ-006 Derived RW = 2*DW + clog2(K), accumulator and result width.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  single-cycle request to begin a multiplication.
REQ-010 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 abort  in  1  synchronous cancel of the running job.
REQ-012 busy  out  1  job in progress.
REQ-013 done  out  1  single-cycle completion pulse.
REQ-014 a_rd_en  out  1  read strobe to memory A.
REQ-015 a_addr  out  AW  A address, row-major, i*K+k.
REQ-016 a_rd_data  in  DW  A data, valid exactly 1 cycle after a_rd_en.
REQ-017 b_rd_en  out  1  read strobe to memory B.
REQ-018 b_addr  out  AW  B address, row-major, k*N+j.
REQ-019 b_rd_data  in  DW  B data, valid exactly 1 cycle after b_rd_en.
REQ-020 r_wr_en  out  1  write strobe to memory R.
REQ-021 r_addr  out  AW  R address, row-major, i*N+j.
REQ-022 r_wr_data  out  RW  R element value.

Function
REQ-023 FSM states IDLE, FETCH, ACC, STORE, DONE.
REQ-024 IDLE: start=1 -> FETCH; i, j, k and accumulator cleared; signed_mode captured into a job register held for the whole job.
REQ-025 FETCH: a_rd_en=b_rd_en=1 for one cycle with current addresses -> ACC.
REQ-026 ACC: accumulator += a_rd_data*b_rd_data (product and accumulator sign-extended when job is signed, zero-extended otherwise, RW bits); k==K-1 -> STORE, else k+1 -> FETCH.
REQ-027 STORE: r_wr_en=1 for one cycle, r_addr=i*N+j, r_wr_data=accumulator; accumulator and k cleared; j wraps at N-1 with i+1; last element (i==M-1, j==N-1) -> DONE, else -> FETCH.
REQ-028 DONE: done=1 for exactly one cycle -> IDLE.
REQ-029 busy=1 in FETCH, ACC and STORE; 0 in IDLE and DONE.
REQ-030 Latency: start accepted at edge 0 -> done high during cycle M*N*(2K+1)+1; exactly M*N writes, in row-major order.
REQ-031 RW chosen so the accumulator never overflows; no saturation or truncation.
REQ-032 start while busy or in DONE is ignored; no queuing.
REQ-033 abort=1 in FETCH/ACC/STORE -> IDLE at next edge; no further reads or writes, no done pulse; abort ignored in IDLE/DONE; abort and start together in IDLE -> start ignored.
REQ-034 a_rd_en, b_rd_en, r_wr_en, done are 0 in every state except as stated above.
REQ-035 Address outputs hold last value when not strobed.

Reset
REQ-036 rst=1 at any time -> IDLE immediately; busy, done, a_rd_en, b_rd_en, r_wr_en = 0; a_addr, b_addr, r_addr, r_wr_data, accumulator, i, j, k = 0.
REQ-037 rst mid-job -> job discarded, no write or done after release; next start runs a full job from element (0,0).

Verification
REQ-038 M=K=N=2, unsigned, A=[[1,2],[3,4]], B=identity -> writes 1,2,3,4 at addresses 0..3, done in cycle 21, busy low afterwards.
REQ-039 M=N=2, K=3, DW=8, unsigned, all elements 255 -> every r_wr_data = 195075, no wrap.
REQ-040 Same sizes, signed, all A=-128, all B=127 -> every r_wr_data = -48768 in RW-bit two's complement; signed, all A=B=-128 -> 49152.
REQ-041 start pulsed again during job, signed_mode toggled mid-job -> ignored; results and done timing identical to single-start run.
REQ-042 abort in the ACC of element (0,1) -> exactly one write (address 0), no done; subsequent start gives full correct result.
REQ-043 rst asserted during STORE of element 2, released, start reissued -> all outputs 0 during reset, complete correct result set, one done pulse.
